// File: rtl/ir_pkg.sv
// Shared defaults and field types for the instruction prefetch queue.
// The opcode/operand split helper works on default-width words.
package ir_pkg;

    localparam int IW_DEF    = 8;
    localparam int OPW_DEF   = 4;
    localparam int DEPTH_DEF = 4;

    typedef logic [OPW_DEF-1:0]        opcode_t;
    typedef logic [IW_DEF-OPW_DEF-1:0] operand_t;

    typedef struct packed {
        opcode_t  opcode;
        operand_t operand;
    } instr_t;

    function automatic instr_t split_word(input logic [IW_DEF-1:0] w);
        instr_t r;
        r.opcode  = w[IW_DEF-1:IW_DEF-OPW_DEF];
        r.operand = w[IW_DEF-OPW_DEF-1:0];
        return r;
    endfunction

endpackage

// File: rtl/ir_fifo.sv
// Generic DEPTH x W circular buffer with occupancy count and sticky overflow flag.
// A push while full is accepted only when a pop frees the head in the same cycle.
module ir_fifo
    import ir_pkg::*;
#(
    parameter int W     = IW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               wdata,
    output logic [W-1:0]               head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          push_ok, pop_ok;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign ovf   = ovf_q;
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        push_ok  = push && (!full || pop);
        pop_ok   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q || (push && full && !pop);
        // Power-of-two depth lets the pointers wrap by natural overflow.
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
        else if (pop_ok && !push_ok) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage carries no reset; contents are meaningless until pushed.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/instr_queue_reg.sv
// Instruction prefetch queue: head opcode to the controller, head operand to the address bus.
// Define INSTR_QUEUE_TRISTATE_EN to float address (all-z) whenever addr_oe is low.
module instr_queue_reg
    import ir_pkg::*;
#(
    parameter int IW    = IW_DEF,
    parameter int OPW   = OPW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [IW-1:0]            val,
    input  logic                     li,
    input  logic                     ei,
    input  logic                     adv,
    output logic [OPW-1:0]           instruction,
    output logic                     instr_valid,
    output logic [IW-OPW-1:0]        address,
    output logic                     addr_oe,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf_err
);

    localparam int ADW = IW - OPW;

    logic [IW-1:0]  head_word;
    logic [OPW-1:0] head_opc;
    logic [ADW-1:0] head_opr;
    logic [ADW-1:0] address_q, address_d;
    logic           addr_oe_q, addr_oe_d;

    ir_fifo #(
        .W     (IW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (li),
        .pop   (adv),
        .wdata (val),
        .head  (head_word),
        .count (count),
        .full  (full),
        .empty (empty),
        .ovf   (ovf_err)
    );

    if (IW == IW_DEF && OPW == OPW_DEF) begin : g_pkg_split
        instr_t head_fields;
        assign head_fields = split_word(head_word);
        assign head_opc    = head_fields.opcode;
        assign head_opr    = head_fields.operand;
    end else begin : g_slice_split
        assign head_opc = head_word[IW-1:IW-OPW];
        assign head_opr = head_word[ADW-1:0];
    end

    assign instr_valid = !empty;
    // Head storage is stale when empty, so the opcode is forced to zero.
    assign instruction = empty ? '0 : head_opc;

    always_comb begin
        address_d = address_q;
        addr_oe_d = 1'b0;
        if (ei && !empty) begin
            address_d = head_opr;
            addr_oe_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            address_q <= '0;
            addr_oe_q <= 1'b0;
        end else begin
            address_q <= address_d;
            addr_oe_q <= addr_oe_d;
        end
    end

    assign addr_oe = addr_oe_q;

`ifdef INSTR_QUEUE_TRISTATE_EN
    assign address = addr_oe_q ? address_q : {ADW{1'bz}};
`else
    assign address = address_q;
`endif

endmodule

// File: tb/tb_instr_queue_reg.sv
// Directed self-checking bench for instr_queue_reg at IW=8, OPW=4, DEPTH=4.
module tb_instr_queue_reg;

    logic       clk;
    logic       rst;
    logic [7:0] val;
    logic       li, ei, adv;
    logic [3:0] instruction;
    logic       instr_valid;
    logic [3:0] address;
    logic       addr_oe;
    logic       full, empty;
    logic [2:0] count;
    logic       ovf_err;

    int n_chk  = 0;
    int n_fail = 0;

    instr_queue_reg #(.IW(8), .OPW(4), .DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .val         (val),
        .li          (li),
        .ei          (ei),
        .adv         (adv),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .address     (address),
        .addr_oe     (addr_oe),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .ovf_err     (ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of control inputs, then sample 1ns after the edge.
    task automatic cyc(input logic l, input logic e, input logic a, input logic [7:0] v);
        li = l; ei = e; adv = a; val = v;
        @(posedge clk);
        #1;
        li = 1'b0; ei = 1'b0; adv = 1'b0; val = 8'h00;
    endtask

    task automatic push(input logic [7:0] v);
        cyc(1'b1, 1'b0, 1'b0, v);
    endtask

    task automatic pop_expect(input string tag, input logic [3:0] opc);
        chk(tag, {28'd0, instruction}, {28'd0, opc});
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
    endtask

    initial begin
        rst = 1'b1; li = 1'b0; ei = 1'b0; adv = 1'b0; val = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", {29'd0, count}, 32'd0);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_instr", {28'd0, instruction}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_oe", {31'd0, addr_oe}, 32'd0);
        chk("rst_ovf", {31'd0, ovf_err}, 32'd0);
        rst = 1'b0;

        // Mid-run async reset with three entries held
        push(8'h01); push(8'h02); push(8'h03);
        chk("pre_rst_count", {29'd0, count}, 32'd3);
        rst = 1'b1;
        #2;
        chk("async_rst_count", {29'd0, count}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_count", {29'd0, count}, 32'd0);
        chk("midrst_empty", {31'd0, empty}, 32'd1);
        chk("midrst_instr", {28'd0, instruction}, 32'd0);
        chk("midrst_oe", {31'd0, addr_oe}, 32'd0);
        chk("midrst_ovf", {31'd0, ovf_err}, 32'd0);

        // Basic push and address drive
        push(8'hA5);
        chk("a5_instr", {28'd0, instruction}, 32'hA);
        chk("a5_valid", {31'd0, instr_valid}, 32'd1);
        chk("a5_count", {29'd0, count}, 32'd1);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        chk("a5_addr", {28'd0, address}, 32'h5);
        chk("a5_oe", {31'd0, addr_oe}, 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        chk("idle_oe", {31'd0, addr_oe}, 32'd0);
        chk("idle_addr_hold", {28'd0, address}, 32'h5);
        pop_expect("a5_pop", 4'hA);
        chk("a5_empty", {31'd0, empty}, 32'd1);

        // Ordering and pointer wrap
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        chk("ord_full", {31'd0, full}, 32'd1);
        chk("ord_count4", {29'd0, count}, 32'd4);
        pop_expect("ord_pop1", 4'h1);
        pop_expect("ord_pop2", 4'h2);
        chk("ord_count2", {29'd0, count}, 32'd2);
        push(8'h55); push(8'h66);
        chk("ord_refull", {31'd0, full}, 32'd1);
        pop_expect("ord_pop3", 4'h3);
        pop_expect("ord_pop4", 4'h4);
        pop_expect("ord_pop5", 4'h5);
        pop_expect("ord_pop6", 4'h6);
        chk("ord_empty", {31'd0, empty}, 32'd1);
        chk("ord_instr0", {28'd0, instruction}, 32'd0);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        chk("pop_empty_count", {29'd0, count}, 32'd0);
        chk("pop_empty_ovf", {31'd0, ovf_err}, 32'd0);

        // Overflow: drop without pop, accept with pop
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        push(8'h77);
        chk("ovf_count", {29'd0, count}, 32'd4);
        chk("ovf_flag", {31'd0, ovf_err}, 32'd1);
        cyc(1'b1, 1'b0, 1'b1, 8'h88);
        chk("ovf_pp_count", {29'd0, count}, 32'd4);
        chk("ovf_sticky", {31'd0, ovf_err}, 32'd1);
        pop_expect("ovf_pop2", 4'h2);
        pop_expect("ovf_pop3", 4'h3);
        pop_expect("ovf_pop4", 4'h4);
        pop_expect("ovf_pop8", 4'h8);
        chk("ovf_empty", {31'd0, empty}, 32'd1);
        chk("ovf_sticky2", {31'd0, ovf_err}, 32'd1);

        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("ovf_cleared", {31'd0, ovf_err}, 32'd0);

        // Push and pop together on empty, then ei captures the pre-pop head
        cyc(1'b1, 1'b0, 1'b1, 8'h9C);
        chk("sim_count", {29'd0, count}, 32'd1);
        chk("sim_instr", {28'd0, instruction}, 32'h9);
        cyc(1'b0, 1'b1, 1'b1, 8'h00);
        chk("sim_addr", {28'd0, address}, 32'hC);
        chk("sim_oe", {31'd0, addr_oe}, 32'd1);
        chk("sim_count0", {29'd0, count}, 32'd0);

        // ei and adv on empty
        cyc(1'b0, 1'b1, 1'b1, 8'h00);
        chk("emp_oe", {31'd0, addr_oe}, 32'd0);
        chk("emp_count", {29'd0, count}, 32'd0);
        chk("emp_ovf", {31'd0, ovf_err}, 32'd0);
`ifdef INSTR_QUEUE_TRISTATE_EN
        n_chk++;
        assert (address === 4'bzzzz) else begin
            n_fail++;
            $error("FAIL emp_addr_z observed=%b expected=zzzz", address);
        end
`else
        chk("emp_addr_hold", {28'd0, address}, 32'hC);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
